// File: rtl/rob_if.sv
// Port bundle for the reorder buffer: dispatch, CDB capture, operand lookup and in-order commit.
interface rob_if #(
  parameter int TAG_W  = 5,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              flush;
  logic              dis_valid;
  logic              dis_wr_reg;
  logic [ADDR_W-1:0] dis_rd_addr;
  logic              dis_ready;
  logic [TAG_W-1:0]  dis_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  rs_tag;
  logic              rs_ready;
  logic [DATA_W-1:0] rs_data;
  logic [TAG_W-1:0]  rt_tag;
  logic              rt_ready;
  logic [DATA_W-1:0] rt_data;
  logic              RB_valid;
  logic [TAG_W-1:0]  RB_tag;
  logic              RB_wen;
  logic [ADDR_W-1:0] RB_addr;
  logic [DATA_W-1:0] RB_data;
  logic [TAG_W:0]    count;
  logic              full;
  logic              empty;

  modport master (
    output flush, dis_valid, dis_wr_reg, dis_rd_addr, cdb_valid, cdb_tag, cdb_data, rs_tag, rt_tag,
    input  dis_ready, dis_tag, rs_ready, rs_data, rt_ready, rt_data,
           RB_valid, RB_tag, RB_wen, RB_addr, RB_data, count, full, empty
  );

  modport slave (
    input  flush, dis_valid, dis_wr_reg, dis_rd_addr, cdb_valid, cdb_tag, cdb_data, rs_tag, rt_tag,
    output dis_ready, dis_tag, rs_ready, rs_data, rt_ready, rt_data,
           RB_valid, RB_tag, RB_wen, RB_addr, RB_data, count, full, empty
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: allocates rename tags at dispatch, captures CDB results and
// retires in program order, presenting a registered commit/register-write port.
module rob #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 5,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic  clock,
  input  logic  reset,
  rob_if.slave  bus
);

  localparam logic [TAG_W:0]   DEPTH_C   = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1);

  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  done_r;
  logic [DEPTH-1:0]  wr_reg_r;
  logic [ADDR_W-1:0] rd_addr_r [DEPTH];
  logic [DATA_W-1:0] data_r    [DEPTH];
  logic [TAG_W-1:0]  head_r;
  logic [TAG_W-1:0]  tail_r;
  logic [TAG_W:0]    count_r;
  logic              full_r;
  logic              empty_r;
  logic              rb_valid_r;
  logic              rb_wen_r;
  logic [TAG_W-1:0]  rb_tag_r;
  logic [ADDR_W-1:0] rb_addr_r;
  logic [DATA_W-1:0] rb_data_r;

  logic              accept_s;
  logic              commit_s;
  logic              wb_s;
  logic [TAG_W:0]    count_nxt_s;
  logic              rs_ready_s;
  logic [DATA_W-1:0] rs_data_s;
  logic              rt_ready_s;
  logic [DATA_W-1:0] rt_data_s;

  // Per-cycle control decisions and next occupancy; a full buffer refuses dispatch even when a commit frees a slot.
  always_comb begin
    accept_s = bus.dis_valid & ~full_r;
    commit_s = busy_r[head_r] & done_r[head_r];
    wb_s     = bus.cdb_valid & busy_r[bus.cdb_tag];
    if (bus.flush) begin
      count_nxt_s = {(TAG_W+1){1'b0}};
    end else if (accept_s && !commit_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!accept_s && commit_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Rs operand lookup with same-cycle CDB bypass.
  always_comb begin
    if (busy_r[bus.rs_tag] && bus.cdb_valid && (bus.cdb_tag == bus.rs_tag)) begin
      rs_ready_s = 1'b1;
      rs_data_s  = bus.cdb_data;
    end else begin
      rs_ready_s = busy_r[bus.rs_tag] & done_r[bus.rs_tag];
      rs_data_s  = data_r[bus.rs_tag];
    end
  end

  // Rt operand lookup with same-cycle CDB bypass.
  always_comb begin
    if (busy_r[bus.rt_tag] && bus.cdb_valid && (bus.cdb_tag == bus.rt_tag)) begin
      rt_ready_s = 1'b1;
      rt_data_s  = bus.cdb_data;
    end else begin
      rt_ready_s = busy_r[bus.rt_tag] & done_r[bus.rt_tag];
      rt_data_s  = data_r[bus.rt_tag];
    end
  end

  // Entry state, pointers, occupancy and the registered commit port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r     <= {DEPTH{1'b0}};
      done_r     <= {DEPTH{1'b0}};
      wr_reg_r   <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_addr_r[i] <= {ADDR_W{1'b0}};
        data_r[i]    <= {DATA_W{1'b0}};
      end
      head_r     <= {TAG_W{1'b0}};
      tail_r     <= {TAG_W{1'b0}};
      count_r    <= {(TAG_W+1){1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      rb_valid_r <= 1'b0;
      rb_wen_r   <= 1'b0;
      rb_tag_r   <= {TAG_W{1'b0}};
      rb_addr_r  <= {ADDR_W{1'b0}};
      rb_data_r  <= {DATA_W{1'b0}};
    end else if (bus.flush) begin
      busy_r     <= {DEPTH{1'b0}};
      done_r     <= {DEPTH{1'b0}};
      head_r     <= {TAG_W{1'b0}};
      tail_r     <= {TAG_W{1'b0}};
      count_r    <= {(TAG_W+1){1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      rb_valid_r <= 1'b0;
      rb_wen_r   <= 1'b0;
    end else begin
      if (wb_s) begin
        done_r[bus.cdb_tag] <= 1'b1;
        data_r[bus.cdb_tag] <= bus.cdb_data;
      end
      if (accept_s) begin
        busy_r[tail_r]    <= 1'b1;
        done_r[tail_r]    <= 1'b0;
        wr_reg_r[tail_r]  <= bus.dis_wr_reg;
        rd_addr_r[tail_r] <= bus.dis_rd_addr;
        tail_r            <= tail_r + TAG_ONE;
      end
      // Commit reads the pre-edge entry, so a CDB hit on the head this cycle cannot alter what retires.
      if (commit_s) begin
        busy_r[head_r] <= 1'b0;
        done_r[head_r] <= 1'b0;
        head_r         <= head_r + TAG_ONE;
        rb_valid_r     <= 1'b1;
        rb_wen_r       <= wr_reg_r[head_r];
        rb_tag_r       <= head_r;
        rb_addr_r      <= rd_addr_r[head_r];
        rb_data_r      <= data_r[head_r];
      end else begin
        rb_valid_r     <= 1'b0;
        rb_wen_r       <= 1'b0;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {(TAG_W+1){1'b0}});
    end
  end

  assign bus.dis_tag   = tail_r;
  assign bus.dis_ready = ~full_r;
  assign bus.rs_ready  = rs_ready_s;
  assign bus.rs_data   = rs_data_s;
  assign bus.rt_ready  = rt_ready_s;
  assign bus.rt_data   = rt_data_s;
  assign bus.RB_valid  = rb_valid_r;
  assign bus.RB_wen    = rb_wen_r;
  assign bus.RB_tag    = rb_tag_r;
  assign bus.RB_addr   = rb_addr_r;
  assign bus.RB_data   = rb_data_r;
  assign bus.count     = count_r;
  assign bus.full      = full_r;
  assign bus.empty     = empty_r;

endmodule

// File: tb/tb_rob.sv
// Bench for rob: vector table, directed corner sequences and random traffic
// checked against a program-order queue model.
module tb_rob;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset;

  rob_if #(.TAG_W(5), .ADDR_W(5), .DATA_W(32)) rb ();

  rob #(.DEPTH(32), .TAG_W(5), .ADDR_W(5), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rb.slave)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: in-flight instructions oldest first; tag is the slot allocated at dispatch.
  typedef struct packed {
    logic [4:0]  tag;
    logic        wr;
    logic [4:0]  addr;
    logic        done;
    logic [31:0] data;
  } ment_t;
  ment_t      mq[$];
  logic [4:0] m_tail;

  typedef struct packed {
    logic        dv;
    logic        wr;
    logic [4:0]  rd;
    logic        cv;
    logic [4:0]  ct;
    logic [31:0] cd;
    logic [4:0]  e_tag;
    logic [5:0]  e_cnt;
    logic        e_rbv;
    logic        e_wen;
    logic [4:0]  e_rbt;
    logic [4:0]  e_rba;
    logic [31:0] e_rbd;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mk(input logic dv, input logic wr, input logic [4:0] rd,
                              input logic cv, input logic [4:0] ct, input logic [31:0] cd,
                              input logic [4:0] e_tag, input logic [5:0] e_cnt,
                              input logic e_rbv, input logic e_wen, input logic [4:0] e_rbt,
                              input logic [4:0] e_rba, input logic [31:0] e_rbd);
    vec_t v;
    v = {dv, wr, rd, cv, ct, cd, e_tag, e_cnt, e_rbv, e_wen, e_rbt, e_rba, e_rbd};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    rb.flush       = 1'b0;
    rb.dis_valid   = 1'b0;
    rb.dis_wr_reg  = 1'b0;
    rb.dis_rd_addr = 5'd0;
    rb.cdb_valid   = 1'b0;
    rb.cdb_tag     = 5'd0;
    rb.cdb_data    = 32'd0;
  endtask

  task automatic opnd_chk(input string nm, input logic [4:0] tag, input logic rdy, input logic [31:0] dat);
    logic        er;
    logic [31:0] ed;
    er = 1'b0;
    ed = 32'd0;
    foreach (mq[i]) begin
      if (mq[i].tag == tag) begin
        if (rb.cdb_valid && rb.cdb_tag == tag) begin
          er = 1'b1;
          ed = rb.cdb_data;
        end else begin
          er = mq[i].done;
          ed = mq[i].data;
        end
      end
    end
    chk({nm, "_ready"}, 32'(rdy), 32'(er));
    if (er) chk({nm, "_data"}, dat, ed);
  endtask

  // Settle inputs, then compare combinational and occupancy outputs with the model.
  task automatic pre_check();
    #1;
    chk("dis_tag", 32'(rb.dis_tag), 32'(m_tail));
    chk("dis_ready", 32'(rb.dis_ready), 32'(mq.size() < DEPTH));
    chk("count", 32'(rb.count), 32'(mq.size()));
    chk("full", 32'(rb.full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(rb.empty), 32'(mq.size() == 0));
    opnd_chk("rs", rb.rs_tag, rb.rs_ready, rb.rs_data);
    opnd_chk("rt", rb.rt_tag, rb.rt_ready, rb.rt_data);
  endtask

  // Advance the model by one edge, clock the DUT, compare the commit port.
  task automatic edge_step();
    ment_t c;
    logic  do_c;
    logic  acc;
    do_c = 1'b0;
    c    = '0;
    if (rb.flush) begin
      mq.delete();
      m_tail = 5'd0;
    end else begin
      acc = rb.dis_valid && (mq.size() < DEPTH);
      if (mq.size() > 0 && mq[0].done) begin
        do_c = 1'b1;
        c    = mq[0];
      end
      if (rb.cdb_valid) begin
        foreach (mq[i]) begin
          if (mq[i].tag == rb.cdb_tag) begin
            mq[i].done = 1'b1;
            mq[i].data = rb.cdb_data;
          end
        end
      end
      if (do_c) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({m_tail, rb.dis_wr_reg, rb.dis_rd_addr, 1'b0, 32'd0});
        m_tail = m_tail + 5'd1;
      end
    end
    @(posedge clock);
    #1;
    chk("RB_valid", 32'(rb.RB_valid), 32'(do_c));
    chk("RB_wen", 32'(rb.RB_wen), 32'(do_c & c.wr));
    if (do_c) begin
      chk("RB_tag", 32'(rb.RB_tag), 32'(c.tag));
      chk("RB_addr", 32'(rb.RB_addr), 32'(c.addr));
      chk("RB_data", rb.RB_data, c.data);
    end
  endtask

  task automatic tick();
    pre_check();
    edge_step();
  endtask

  task automatic dispatch(input logic wr, input logic [4:0] rd);
    idle();
    rb.dis_valid   = 1'b1;
    rb.dis_wr_reg  = wr;
    rb.dis_rd_addr = rd;
    tick();
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    idle();
    rb.cdb_valid = 1'b1;
    rb.cdb_tag   = tag;
    rb.cdb_data  = data;
    tick();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    mq.delete();
    m_tail = 5'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_count", 32'(rb.count), 32'd0);
    chk("rst_empty", 32'(rb.empty), 32'd1);
    chk("rst_full", 32'(rb.full), 32'd0);
    chk("rst_dis_ready", 32'(rb.dis_ready), 32'd1);
    chk("rst_RB_valid", 32'(rb.RB_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    rb.rs_tag = 5'd31;
    rb.rt_tag = 5'd30;
    idle();

    // In-order retirement of an out-of-order completion.
    vecs[0]  = mk(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,  5'd0, 6'd1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0,  5'd1, 6'd2, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,  5'd2, 6'd3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[3]  = mk(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'hAA, 5'd3, 6'd3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[4]  = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd3, 6'd3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[5]  = mk(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h55, 5'd3, 6'd3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[6]  = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd3, 6'd2, 1'b1, 1'b1, 5'd0, 5'd5, 32'h55);
    vecs[7]  = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd3, 6'd1, 1'b1, 1'b1, 5'd1, 5'd6, 32'hAA);
    vecs[8]  = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd3, 6'd1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[9]  = mk(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h77, 5'd3, 6'd1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
    vecs[10] = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd3, 6'd0, 1'b1, 1'b1, 5'd2, 5'd7, 32'h77);

    do_reset();
    for (int k = 0; k < 11; k++) begin
      idle();
      rb.dis_valid   = vecs[k].dv;
      rb.dis_wr_reg  = vecs[k].wr;
      rb.dis_rd_addr = vecs[k].rd;
      rb.cdb_valid   = vecs[k].cv;
      rb.cdb_tag     = vecs[k].ct;
      rb.cdb_data    = vecs[k].cd;
      pre_check();
      chk("vec_dis_tag", 32'(rb.dis_tag), 32'(vecs[k].e_tag));
      edge_step();
      chk("vec_count", 32'(rb.count), 32'(vecs[k].e_cnt));
      chk("vec_RB_valid", 32'(rb.RB_valid), 32'(vecs[k].e_rbv));
      chk("vec_RB_wen", 32'(rb.RB_wen), 32'(vecs[k].e_wen));
      if (vecs[k].e_rbv) begin
        chk("vec_RB_tag", 32'(rb.RB_tag), 32'(vecs[k].e_rbt));
        chk("vec_RB_addr", 32'(rb.RB_addr), 32'(vecs[k].e_rba));
        chk("vec_RB_data", rb.RB_data, vecs[k].e_rbd);
      end
    end

    // Fill to capacity, overflow attempt, commit while full, pointer wrap.
    do_reset();
    for (int k = 0; k < DEPTH; k++) dispatch(1'b1, 5'(k));
    chk("t3_full", 32'(rb.full), 32'd1);
    chk("t3_dis_ready", 32'(rb.dis_ready), 32'd0);
    chk("t3_count", 32'(rb.count), 32'd32);
    dispatch(1'b1, 5'd9);
    chk("t3_tail_stays", 32'(rb.dis_tag), 32'd0);
    chk("t3_count_33", 32'(rb.count), 32'd32);
    cdb(5'd0, 32'hC0DE);
    dispatch(1'b1, 5'd9);
    chk("t3_commit_full", 32'(rb.RB_valid), 32'd1);
    chk("t3_count_after", 32'(rb.count), 32'd31);
    idle();
    rb.dis_valid = 1'b1;
    pre_check();
    chk("t3_wrap_tag", 32'(rb.dis_tag), 32'd0);
    edge_step();
    chk("t3_refill", 32'(rb.count), 32'd32);

    // Dispatch and commit in the same cycle.
    do_reset();
    for (int k = 0; k < 10; k++) dispatch(1'b1, 5'(k + 3));
    cdb(5'd0, 32'h1111);
    dispatch(1'b1, 5'd20);
    chk("t4_count", 32'(rb.count), 32'd10);
    chk("t4_RB_tag", 32'(rb.RB_tag), 32'd0);
    chk("t4_tail", 32'(rb.dis_tag), 32'd11);
    cdb(5'd1, 32'h2222);
    idle();
    tick();
    chk("t4_head", 32'(rb.RB_tag), 32'd1);

    // CDB bypass on operand lookup; non-writing entry commits with RB_wen low.
    do_reset();
    dispatch(1'b1, 5'd1);
    dispatch(1'b1, 5'd2);
    dispatch(1'b1, 5'd3);
    dispatch(1'b0, 5'd4);
    cdb(5'd0, 32'h10);
    cdb(5'd1, 32'h11);
    rb.rs_tag = 5'd3;
    idle();
    rb.cdb_valid = 1'b1;
    rb.cdb_tag   = 5'd2;
    rb.cdb_data  = 32'h12;
    pre_check();
    chk("t5_rs_not_ready", 32'(rb.rs_ready), 32'd0);
    edge_step();
    idle();
    rb.cdb_valid = 1'b1;
    rb.cdb_tag   = 5'd3;
    rb.cdb_data  = 32'h1234;
    pre_check();
    chk("t5_rs_bypass_ready", 32'(rb.rs_ready), 32'd1);
    chk("t5_rs_bypass_data", rb.rs_data, 32'h1234);
    edge_step();
    idle();
    tick();
    chk("t5_RB_tag", 32'(rb.RB_tag), 32'd3);
    chk("t5_RB_wen", 32'(rb.RB_wen), 32'd0);
    chk("t5_RB_valid", 32'(rb.RB_valid), 32'd1);

    // Flush against pending commit, dispatch and CDB; then async reset mid-commit.
    do_reset();
    for (int k = 0; k < 8; k++) dispatch(1'b1, 5'(k));
    cdb(5'd0, 32'hF0);
    idle();
    rb.flush     = 1'b1;
    rb.dis_valid = 1'b1;
    rb.cdb_valid = 1'b1;
    rb.cdb_tag   = 5'd1;
    rb.cdb_data  = 32'hF1;
    tick();
    chk("t6_count", 32'(rb.count), 32'd0);
    chk("t6_empty", 32'(rb.empty), 32'd1);
    chk("t6_RB_valid", 32'(rb.RB_valid), 32'd0);
    dispatch(1'b1, 5'd12);
    dispatch(1'b1, 5'd13);
    cdb(5'd0, 32'hBEEF);
    idle();
    tick();
    chk("t6_commit_seen", 32'(rb.RB_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_RB_valid", 32'(rb.RB_valid), 32'd0);
    chk("t6_rst_RB_wen", 32'(rb.RB_wen), 32'd0);
    chk("t6_rst_count", 32'(rb.count), 32'd0);
    chk("t6_rst_empty", 32'(rb.empty), 32'd1);
    do_reset();

    // Random traffic against the queue model, alternating fill- and drain-heavy phases.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit drain;
      drain = ((cyc / 300) % 2) == 1;
      idle();
      rb.dis_valid   = $urandom_range(99) < (drain ? 30 : 85);
      rb.dis_wr_reg  = 1'($urandom_range(1));
      rb.dis_rd_addr = 5'($urandom);
      if ($urandom_range(99) < (drain ? 80 : 40)) begin
        rb.cdb_valid = 1'b1;
        rb.cdb_data  = $urandom;
        if (mq.size() > 0 && $urandom_range(9) != 0)
          rb.cdb_tag = mq[$urandom_range(mq.size() - 1)].tag;
        else
          rb.cdb_tag = 5'($urandom);
      end
      rb.flush  = ($urandom_range(499) == 0);
      rb.rs_tag = 5'($urandom);
      rb.rt_tag = (mq.size() > 0) ? mq[$urandom_range(mq.size() - 1)].tag : 5'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
